// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_iter_pkg;

   localparam int W_DEF = 32;

   // Quotient returned on divide-by-zero, truncated to the operand width by users.
   localparam logic [63:0] DZ_QUO = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_iter_sub33.sv
// N-bit ripple subtractor a - b: inverted subtrahend with carry-in 1, returning
// the low N-1 difference bits and the sign (MSB) of the full result.
module div_sub33 #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-2:0] diff,
   output logic         sign
);

   logic [N-1:0] c;
   logic [N-1:0] bn;

   assign c[0] = 1'b1;
   assign bn   = ~b;

   for (genvar i = 0; i < N - 1; i++) begin : g_cell
      assign diff[i]  = a[i] ^ bn[i] ^ c[i];
      assign c[i + 1] = (a[i] & bn[i]) | (c[i] & (a[i] ^ bn[i]));
   end

   assign sign = a[N-1] ^ bn[N-1] ^ c[N-1];

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider producing quotient (lo) and remainder (hi), one
// quotient bit per cycle. Signed DIV support is compiled in with DIV_SIGNED_EN.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sgn,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic         dz,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   localparam int CW = $clog2(W);

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   rem, quo, dvs_mag, dvd_raw;
   logic           neg_q, neg_r;
   logic           load, sgn_eff, dvd_neg, dvs_neg;
   logic [W-1:0]   trial;
   logic           trial_neg;

   assign load    = start && (state == IDLE || state == DONE);
   assign sgn_eff = SIGNED_EN & sgn;
   assign dvd_neg = sgn_eff & dividend[W-1];
   assign dvs_neg = sgn_eff & divisor[W-1];

   // Trial subtraction of the shifted partial remainder, W+1 bits wide.
   div_sub33 #(.N(W + 1)) u_sub (
      .a    ({rem, quo[W-1]}),
      .b    ({1'b0, dvs_mag}),
      .diff (trial),
      .sign (trial_neg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == FIX);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs_mag <= '0;
         dvd_raw <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         lo      <= '0;
         hi      <= '0;
      end else if (load) begin
         cnt     <= CW'(W - 1);
         rem     <= '0;
         quo     <= dvd_neg ? -dividend : dividend;
         dvs_mag <= dvs_neg ? -divisor : divisor;
         dvd_raw <= dividend;
         neg_q   <= dvd_neg ^ dvs_neg;
         neg_r   <= dvd_neg;
      end else if (state == RUN) begin
         cnt <= cnt - 1'b1;
         rem <= trial_neg ? {rem[W-2:0], quo[W-1]} : trial;
         quo <= {quo[W-2:0], ~trial_neg};
      end else if (state == FIX) begin
         // A zero divisor bypasses sign correction and reports the raw dividend.
         dz <= (dvs_mag == '0);
         if (dvs_mag == '0) begin
            lo <= W'(DZ_QUO);
            hi <= dvd_raw;
         end else begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem : rem;
         end
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scenario tasks with a queue of expected
// {dz, hi, lo} results; honours DIV_SIGNED_EN in its reference model.
module tb_div_iter;

   localparam int W = 32;

`ifdef DIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sgn;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic         dz;
   logic [W-1:0] lo;
   logic [W-1:0] hi;

   logic [2*W:0] exp_q[$];
   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   div_iter #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sgn      (sgn),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .dz       (dz),
      .lo       (lo),
      .hi       (hi)
   );

   // Reference result packed as {dz, hi, lo}.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      logic [W-1:0] q, r;
      logic sg;
      sg = SIGNED_EN & s;
      if (b == 0) return {1'b1, a, {W{1'b1}}};
      if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {1'b0, r, q};
   endfunction

   // Pulses start for one edge; returns at #1 after that edge.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input bit track);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
      if (track) exp_q.push_back(model(a, b, s));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts cycles until done (bounded) and the cycles busy was seen high.
   task automatic wait_done(output int n, output int bc);
      n  = 0;
      bc = 0;
      while (!done && n < 100) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, dz, lo, hi} !== '0)
         $display("FAIL reset: got busy=%b done=%b dz=%b lo=%h hi=%h exp all 0",
                  busy, done, dz, lo, hi);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_divu_basic();
      int n, bc;
      logic [2*W:0] exp;
      drive_start(32'd100, 32'd7, 1'b0, 1'b1);
      wait_done(n, bc);
      exp = exp_q.pop_front();
      checks++;
      if ({dz, hi, lo} !== exp) $display("FAIL divu_100_7: got %h exp %h", {dz, hi, lo}, exp);
      else passed++;
      checks++;
      if (n !== 33) $display("FAIL latency: got %0d exp 33", n);
      else passed++;
      checks++;
      if (bc !== 33) $display("FAIL busy_len: got %0d exp 33", bc);
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy, dz, hi, lo} !== {2'b00, exp})
         $display("FAIL done_pulse_hold: got done=%b busy=%b res=%h exp 0 0 %h",
                  done, busy, {dz, hi, lo}, exp);
      else passed++;
   endtask

   task automatic test_signed();
      logic [W-1:0] ta [5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [W-1:0] tb [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
      logic         ts [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         int n, bc;
         logic [2*W:0] exp;
         drive_start(ta[i], tb[i], ts[i], 1'b1);
         wait_done(n, bc);
         exp = exp_q.pop_front();
         checks++;
         if ({dz, hi, lo} !== exp)
            $display("FAIL signed_%0d: got %h exp %h", i, {dz, hi, lo}, exp);
         else passed++;
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] ta [2] = '{32'h1234_5678, 32'h8765_4321};
      logic         ts [2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         int n, bc;
         logic [2*W:0] exp;
         drive_start(ta[i], '0, ts[i], 1'b1);
         wait_done(n, bc);
         exp = exp_q.pop_front();
         checks++;
         if ({dz, hi, lo} !== exp)
            $display("FAIL div_zero_%0d: got %h exp %h", i, {dz, hi, lo}, exp);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         int n, bc;
         logic [2*W:0] exp;
         logic [W-1:0] a, b;
         a = $urandom;
         b = (i % 2 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
         drive_start(a, b, 1'($urandom_range(0, 1)), 1'b1);
         wait_done(n, bc);
         exp = exp_q.pop_front();
         checks++;
         if ({dz, hi, lo} !== exp)
            $display("FAIL random_%0d: got %h exp %h", i, {dz, hi, lo}, exp);
         else passed++;
      end
   endtask

   task automatic test_start_ignored();
      int n, bc;
      logic [2*W:0] exp;
      drive_start(32'd1000, 32'd9, 1'b0, 1'b1);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      drive_start(32'd55, 32'd5, 1'b0, 1'b0);
      wait_done(n, bc);
      exp = exp_q.pop_front();
      checks++;
      if ({dz, hi, lo} !== exp) $display("FAIL start_ignored: got %h exp %h", {dz, hi, lo}, exp);
      else passed++;
      checks++;
      if (n !== 27) $display("FAIL start_ignored_lat: got %0d exp 27", n);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int n, bc;
      logic [2*W:0] exp;
      drive_start(32'd12345, 32'd100, 1'b0, 1'b1);
      wait_done(n, bc);
      exp = exp_q.pop_front();
      checks++;
      if ({dz, hi, lo} !== exp) $display("FAIL b2b_first: got %h exp %h", {dz, hi, lo}, exp);
      else passed++;
      // Already in the done cycle: raise start now so the next edge accepts it.
      dividend = 32'hFFFF_FFF0;
      divisor  = 32'd3;
      sgn      = 1'b1;
      start    = 1'b1;
      exp_q.push_back(model(32'hFFFF_FFF0, 32'd3, 1'b1));
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n, bc);
      exp = exp_q.pop_front();
      checks++;
      if ({dz, hi, lo} !== exp) $display("FAIL b2b_second: got %h exp %h", {dz, hi, lo}, exp);
      else passed++;
      checks++;
      if (n + 1 !== 34) $display("FAIL b2b_gap: got %0d exp 34", n + 1);
      else passed++;
   endtask

   task automatic test_reset_mid_run();
      int n, bc;
      logic [2*W:0] exp;
      drive_start(32'd999, 32'd4, 1'b0, 1'b0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #2;
      checks++;
      if ({busy, done, dz, lo, hi} !== '0)
         $display("FAIL reset_mid_run: got busy=%b done=%b dz=%b lo=%h hi=%h exp all 0",
                  busy, done, dz, lo, hi);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      drive_start(32'd77, 32'd10, 1'b0, 1'b1);
      wait_done(n, bc);
      exp = exp_q.pop_front();
      checks++;
      if ({dz, hi, lo} !== exp) $display("FAIL after_reset: got %h exp %h", {dz, hi, lo}, exp);
      else passed++;
      checks++;
      if (n !== 33) $display("FAIL after_reset_lat: got %0d exp 33", n);
      else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
